// File: rtl/gt_miss_fill_unit.sv
// Miss queue and line-fill engine behind GT_cache: coalesces repeat misses,
// waits a fixed memory latency, then streams each line back as byte beats.
module gt_miss_fill_unit #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned LINE_BYTES  = 8,
  parameter int unsigned QDEPTH      = 4,
  parameter int unsigned MEM_LATENCY = 10
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              miss_valid,
  output logic              miss_ready,
  input  logic [ADDR_W-1:0] miss_addr,
  output logic              fill_valid,
  input  logic              fill_ready,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [7:0]        fill_data,
  output logic              fill_last,
  output logic              busy,
  output logic              merged
);

  localparam int unsigned OFF_W = $clog2(LINE_BYTES);
  localparam int unsigned PTR_W = $clog2(QDEPTH);
  localparam int unsigned CNT_W = $clog2(QDEPTH + 1);
  localparam int unsigned LAT_W = $clog2(MEM_LATENCY + 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_BYTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;

  logic [ADDR_W-1:0] q_addr [QDEPTH];
  logic [QDEPTH-1:0] q_vld;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  state_t            state;
  logic [LAT_W-1:0]  cnt;
  logic [OFF_W-1:0]  beat;

  logic [ADDR_W-1:0] aligned_c;
  logic              accept_c;
  logic              pop_c;
  logic              match_c;
  logic              push_c;
  logic [CNT_W-1:0]  count_nxt_c;

  // Accept/coalesce decode; the head stops counting as a match on its final beat
  always_comb begin
    aligned_c = miss_addr & LINE_MASK;
    accept_c  = miss_valid && miss_ready;
    pop_c     = fill_valid && fill_ready && fill_last;
    match_c   = 1'b0;
    for (int i = 0; i < QDEPTH; i++) begin
      if (q_vld[i] && (q_addr[i] == aligned_c) && !(pop_c && (PTR_W'(i) == rd_ptr))) begin
        match_c = 1'b1;
      end
    end
    push_c      = accept_c && !match_c;
    count_nxt_c = count + CNT_W'(push_c) - CNT_W'(pop_c);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < QDEPTH; i++) q_addr[i] <= '0;
      q_vld      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      state      <= S_IDLE;
      cnt        <= '0;
      beat       <= '0;
      miss_ready <= 1'b1;
      fill_valid <= 1'b0;
      fill_addr  <= '0;
      fill_data  <= '0;
      fill_last  <= 1'b0;
      busy       <= 1'b0;
      merged     <= 1'b0;
    end else begin
      merged     <= accept_c && match_c;
      count      <= count_nxt_c;
      miss_ready <= (count_nxt_c != CNT_W'(QDEPTH));
      busy       <= (count_nxt_c != '0);

      if (push_c) begin
        q_addr[wr_ptr] <= aligned_c;
        q_vld[wr_ptr]  <= 1'b1;
        wr_ptr         <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) begin
        q_vld[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + PTR_W'(1);
      end

      // Service engine: head stays queued (and mergeable) until its last beat
      case (state)
        S_IDLE: begin
          if (count != '0) begin
            state <= S_WAIT;
            cnt   <= LAT_W'(MEM_LATENCY);
          end
        end
        S_WAIT: begin
          if (cnt == LAT_W'(1)) begin
            state      <= S_BURST;
            beat       <= '0;
            fill_valid <= 1'b1;
            fill_addr  <= q_addr[rd_ptr];
            fill_data  <= q_addr[rd_ptr][7:0];
            fill_last  <= 1'b0;
          end else begin
            cnt <= cnt - LAT_W'(1);
          end
        end
        S_BURST: begin
          if (fill_ready) begin
            if (fill_last) begin
              state      <= S_IDLE;
              fill_valid <= 1'b0;
              fill_last  <= 1'b0;
              beat       <= '0;
            end else begin
              beat      <= beat + OFF_W'(1);
              fill_data <= fill_data + 8'd1;
              fill_last <= (beat == OFF_W'(LINE_BYTES - 2));
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
